// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   RV32I load/store unit for the multi-cycle core. Accepts one request at a
//   time from execute, drives a word-wide data memory through a strobe/ack
//   handshake and returns a single-cycle response carrying the extended load
//   data, the echoed destination register and an error code.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   req_*           request channel (valid/ready), fields latched on accept
//   resp_*          one-cycle response pulse: data, rd and error code
//                   (00 ok, 01 misaligned, 10 timeout, 11 illegal funct3)
//   mem_*           data memory: word address, one-cycle read/write strobes,
//                   byte enables, lane-replicated write data, read data, ack
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic [1:0]        resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_data_q;
    logic [4:0]        resp_rd_q;
    logic [1:0]        resp_err_q;

    logic              req_illegal, req_misaligned;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_lanes;
    logic              req_accept, issue_access, resp_load;
    logic [1:0]        resp_err_d;
    logic [31:0]       load_data, rdata_shift;
    logic [15:0]       half_sel;

    // Address bits above the memory window wrap silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Request decode: legality, alignment, byte lanes and replicated store data.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req_illegal     = 1'b0;
        req_misaligned  = 1'b0;
        req_be          = 4'b1111;
        req_wdata_lanes = req_wdata;
        if (req_store) begin
            req_illegal = (req_funct3 >= 3'd3);
        end else begin
            req_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        end
        // funct3[1:0] encodes width for both signed and unsigned loads.
        case (req_funct3[1:0])
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = 1'b0;
        endcase
        if (req_store) begin
            case (req_funct3[1:0])
                2'd0: begin
                    req_be          = 4'b0001 << req_addr[1:0];
                    req_wdata_lanes = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    req_be          = 4'b0011 << {req_addr[1], 1'b0};
                    req_wdata_lanes = {2{req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load extraction from the returned word using the latched byte offset.
    always_comb begin
        rdata_shift = mem_rdata >> {lane_q, 3'b000};
        half_sel    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'd0:    load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_data = {24'd0, rdata_shift[7:0]};
            3'd5:    load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_accept   = 1'b0;
        issue_access = 1'b0;
        resp_load    = 1'b0;
        resp_err_d   = ERR_OK;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_accept = 1'b1;
                    state_d    = S_RESP;
                    // Illegal width takes priority over misalignment.
                    if (req_illegal) begin
                        resp_load  = 1'b1;
                        resp_err_d = ERR_ILLEGAL;
                    end else if (req_misaligned) begin
                        resp_load  = 1'b1;
                        resp_err_d = ERR_MISALIGN;
                    end else begin
                        issue_access = 1'b1;
                        state_d      = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d   = S_RESP;
                    resp_load = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d   = S_RESP;
                    resp_load = 1'b1;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d    = S_RESP;
                    resp_load  = 1'b1;
                    resp_err_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            rd_q        <= 5'd0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            resp_data_q <= 32'd0;
            resp_rd_q   <= 5'd0;
            resp_err_q  <= ERR_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_accept) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                lane_q   <= req_addr[1:0];
                rd_q     <= req_rd;
            end
            // The memory bus only changes when a real access is issued.
            if (issue_access) begin
                mem_addr_q  <= req_addr[ADDR_W+1:2];
                mem_be_q    <= req_be;
                mem_wdata_q <= req_wdata_lanes;
            end
            if (resp_load) begin
                resp_err_q <= resp_err_d;
                // Errors from IDLE never look at store_q: their code is non-zero.
                if (resp_err_d == ERR_OK && !store_q) begin
                    resp_data_q <= load_data;
                    resp_rd_q   <= rd_q;
                end else begin
                    resp_data_q <= 32'd0;
                    resp_rd_q   <= 5'd0;
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    // Strobes and the response pulse are suppressed while reset is asserted.
    assign resp_valid = (state_q == S_RESP) && !rst;
    assign mem_rden   = (state_q == S_ACCESS) && !store_q && !rst;
    assign mem_wren   = (state_q == S_ACCESS) && store_q && !rst;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit: load extraction, store lanes, error
//   priority, timeout, reset in flight and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int ADDR_W  = 7;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [4:0]        resp_rd;
    logic [1:0]        resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic              mem_wren;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    int tests = 0;
    int fails = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int resp_count = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // A strobe or response high at a rising edge is one cycle of that pulse.
    always @(posedge clk) begin
        if (mem_rden === 1'b1) rd_pulses++;
        if (mem_wren === 1'b1) wr_pulses++;
        if (resp_valid === 1'b1) resp_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns just after the accept edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        req_rd     = rd;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    // Load acked in its strobe cycle; checks the bus and the response.
    task automatic load_ack0(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [4:0] rd, input logic [31:0] exp);
        logic [6:0] exp_addr;
        exp_addr = 7'(a >> 2);
        issue(1'b0, f3, a, 32'h0, rd);
        check({tag, "_rden"}, {31'd0, mem_rden}, 32'd1);
        check({tag, "_addr"}, {25'd0, mem_addr}, {25'd0, exp_addr});
        check({tag, "_be"}, {28'd0, mem_be}, 32'hF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_rd"}, {27'd0, resp_rd}, {27'd0, rd});
        check({tag, "_err"}, {30'd0, resp_err}, 32'd0);
        tick();
    endtask

    // Store acked in its strobe cycle; checks lanes, single pulse and response.
    task automatic store_ack0(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
        int wr_base;
        wr_base = wr_pulses;
        issue(1'b1, f3, a, d, 5'd9);
        check({tag, "_wren"}, {30'd0, mem_wren, mem_rden}, 32'd2);
        check({tag, "_addr"}, {25'd0, mem_addr}, {25'd0, 7'(a >> 2)});
        check({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
        check({tag, "_early_resp"}, {31'd0, resp_valid}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_resp"}, {resp_data[24:0], resp_rd, resp_err}, 32'd0);
        tick();
        check({tag, "_pulses"}, 32'(wr_pulses - wr_base), 32'd1);
    endtask

    // Request rejected in IDLE: response next cycle, no strobe.
    task automatic early_err(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [1:0] exp_err);
        int strobe_base;
        strobe_base = rd_pulses + wr_pulses;
        issue(st, f3, a, 32'hFFFF_FFFF, 5'd3);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_err"}, {30'd0, resp_err}, {30'd0, exp_err});
        check({tag, "_data_rd"}, {resp_data[26:0], resp_rd}, 32'd0);
        tick();
        check({tag, "_ready"}, {30'd0, req_ready, resp_valid}, 32'd2);
        check({tag, "_no_strobe"}, 32'(rd_pulses + wr_pulses - strobe_base), 32'd0);
    endtask

    initial begin
        int n;
        int base_rd;
        int base_resp;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        mem_rdata  = 32'h80FF_7F01;
        mem_ack    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp", {resp_valid, resp_data[23:0], resp_rd, resp_err}, 32'd0);
        check("rst_strobes", {30'd0, mem_rden, mem_wren}, 32'd0);
        check("rst_mem_bus", {21'd0, mem_addr, mem_be}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // Load extraction from word 0x80FF7F01
        load_ack0("lb_06",  3'd0, 32'h0000_0006, 5'd5,  32'hFFFF_FFFF);
        load_ack0("lbu_06", 3'd4, 32'h0000_0006, 5'd7,  32'h0000_00FF);
        load_ack0("lb_01",  3'd0, 32'h0000_0001, 5'd8,  32'h0000_007F);
        load_ack0("lh_02",  3'd1, 32'h0000_0002, 5'd10, 32'hFFFF_80FF);
        load_ack0("lhu_00", 3'd5, 32'h0000_0000, 5'd11, 32'h0000_7F01);
        load_ack0("lw_04",  3'd2, 32'h0000_0004, 5'd31, 32'h80FF_7F01);
        load_ack0("lw_wrap", 3'd2, 32'hFFFF_FE04, 5'd1, 32'h80FF_7F01);

        // Store lanes
        store_ack0("sh_0a", 3'd1, 32'h0000_000A, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        store_ack0("sb_03", 3'd0, 32'h0000_0003, 32'h0000_00EF, 4'b1000, 32'hEFEF_EFEF);
        store_ack0("sw_10", 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Errors decided in IDLE, illegal ahead of misaligned
        early_err("lw_mis",   1'b0, 3'd2, 32'h0000_0005, 2'b01);
        early_err("ld3_ill",  1'b0, 3'd3, 32'h0000_0005, 2'b11);
        early_err("ld7_ill",  1'b0, 3'd7, 32'h0000_0000, 2'b11);
        early_err("st4_ill",  1'b1, 3'd4, 32'h0000_0000, 2'b11);
        early_err("sh_mis",   1'b1, 3'd1, 32'h0000_0001, 2'b01);
        early_err("lhu_mis",  1'b0, 3'd5, 32'h0000_0003, 2'b01);

        // Timeout: no ack at all, then a stray ack afterwards
        base_rd   = rd_pulses;
        base_resp = resp_count;
        issue(1'b0, 3'd2, 32'h0000_0000, 32'h0, 5'd6);
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        // n counts the ACCESS cycle plus the cycles spent waiting.
        check("to_wait_cycles", 32'(n - 1), 32'(TIMEOUT));
        check("to_err", {30'd0, resp_err}, 32'd2);
        check("to_data_rd", {resp_data[26:0], resp_rd}, 32'd0);
        tick();
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("to_one_rden", 32'(rd_pulses - base_rd), 32'd1);
        check("to_late_ack", 32'(resp_count - base_resp), 32'd1);
        check("to_ready", {31'd0, req_ready}, 32'd1);

        // Reset while waiting; a late ack must not produce a response
        base_rd   = rd_pulses;
        base_resp = resp_count;
        issue(1'b0, 3'd2, 32'h0000_0010, 32'h0, 5'd4);
        tick();
        check("wait_strobe_low", {30'd0, mem_rden, mem_wren}, 32'd0);
        check("wait_addr_held", {25'd0, mem_addr}, 32'd4);
        tick();
        rst = 1'b1;
        check("rst_wait_strobe", {31'd0, mem_rden}, 32'd0);
        tick();
        check("rst_wait_ready", {30'd0, req_ready, resp_valid}, 32'd2);
        rst = 1'b0;
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("rst_no_resp", 32'(resp_count - base_resp), 32'd0);
        check("rst_one_rden", 32'(rd_pulses - base_rd), 32'd1);

        // Back-to-back requests with req_valid and mem_ack held high
        base_rd    = rd_pulses;
        mem_ack    = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0008;
        req_rd     = 5'd12;
        req_valid  = 1'b1;
        tick();
        check("b2b_access", {30'd0, req_ready, mem_rden}, 32'd1);
        tick();
        check("b2b_resp1", {30'd0, req_ready, resp_valid}, 32'd1);
        tick();
        check("b2b_idle", {30'd0, req_ready, resp_valid}, 32'd2);
        tick();
        req_valid = 1'b0;
        check("b2b_access2", {30'd0, req_ready, mem_rden}, 32'd1);
        tick();
        check("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        check("b2b_data2", resp_data, 32'h80FF_7F01);
        tick();
        mem_ack = 1'b0;
        check("b2b_two_rden", 32'(rd_pulses - base_rd), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
